codificador_4a2_sync: RTL and testbench
=======================================

Name: codificador_4a2_sync

Overview:
- Registered 4-to-2 priority encoder with input synchronisation, debounce and event counting; the inverse of the team's 2-to-4 decoder.
- Turns a 4-line one-hot request bus (buttons/selects from the board) into a 2-bit code, a one-cycle valid strobe and a running event count.
- Its output feeds the decoder and the counter logic downstream.

Parameters:
- DEB_CYCLES, 4, consecutive clock edges the synchronised input must hold one nonzero value before an event is emitted; legal range 1..255.
- CNT_W, 8, width of the event counter.

Ports:
- clk, input, 1, system clock, rising-edge.
- rst, input, 1, asynchronous active-high reset.
- en, input, 1, enables detection of new events.
- clear_cnt, input, 1, synchronous clear of count.
- A, input, 4, asynchronous request lines.
- Y, output, 4→2: Y output, 2, encoded code of the last emitted event (registered).
- valid, output, 1, one-cycle strobe, high only in EMIT.
- multi, output, 1, last emitted event had more than one line high (registered).
- any, output, 1, synchronised input is nonzero (registered).
- count, output, CNT_W, number of emitted events, modulo 2^CNT_W.

Behaviour:
- Reset (async, immediate): state=IDLE, both sync stages=0, snapshot=0, deb_cnt=0, Y=2'b00, valid=0, multi=0, any=0, count=0. Asserting rst mid-operation aborts any debounce or hold in progress.
- Sync: a_s is A through two flip-flops (2-edge latency). any = |a_s.
- Encoding is highest set bit wins: 1xxx→11, 01xx→10, 001x→01, 0001→00.
- multi = more than one bit of snapshot set.
- IDLE: on an edge with en=1 and a_s≠0, load snapshot=a_s. This edge counts as stable edge 1.
  - DEB_CYCLES=1 → go to EMIT.
  - Otherwise → go to DEBOUNCE.
  - a_s=0 or en=0 → stay in IDLE.
- DEBOUNCE, per edge:
  - en=0 → IDLE.
  - a_s=0 → IDLE.
  - a_s≠snapshot, nonzero → reload snapshot=a_s, stable count restarts at 1, stay.
  - a_s=snapshot → stable count+1. On reaching DEB_CYCLES → EMIT.
- On the edge entering EMIT:
  - Y←encode(snapshot), multi←(popcount(snapshot)>1).
  - count←count+1, wrapping from all-ones to 0.
  - If clear_cnt is high on that edge, count←0 and the increment is lost (clear has priority).
- EMIT: lasts exactly one cycle with valid=1, then goes to WAIT_RELEASE unconditionally. en is ignored.
- WAIT_RELEASE: stays until an edge with a_s=0, then → IDLE. Changes to a nonzero a_s are ignored, so there are no repeat events while held. en is ignored.
- Y and multi hold their value between events. valid=0 in every state except EMIT.
- clear_cnt outside EMIT: count←0 on the next edge; no effect on the FSM.
- Latency: A stable before edge 0 → valid high in the cycle after edge DEB_CYCLES+1. For DEB_CYCLES=4, valid follows edge 5.
- A minimum of one a_s=0 edge is required between two events.
- After reset is released with A held nonzero: a normal event is emitted after sync plus debounce.

Test Plan:
- Reset, then A=4'b0100 held, DEB_CYCLES=4 → valid single pulse in the cycle after edge 5; Y=10, multi=0, count=1; no second pulse while A is held. Then A=0 followed by A=0001 → second pulse, Y=00, count=2.
- A=4'b1010 held → Y=11, multi=1, count increments by 1.
- Bounce: A=0010 for 2 cycles, 0 for 1 cycle, 0010 for 2 cycles, 0 → no valid, count unchanged. Then A=0010 held 4+ cycles → one pulse, Y=01.
- en=0 with A=1000 held for 10 cycles → no pulse. Raise en while A stays 1000 → pulse DEB_CYCLES+0..1 edges later, Y=11. Drop en mid-debounce → return to IDLE, no pulse.
- Counter: with CNT_W=2, emit 5 events → count sequence 1,2,3,0,1. Assert clear_cnt coincident with a sixth EMIT → count=0, valid still pulses, Y updated.
- Async reset mid-DEBOUNCE and mid-WAIT_RELEASE → all outputs go to their reset values immediately without a clock edge. With A held 0100 through release → exactly one pulse after DEB_CYCLES+2 edges.

Source files
------------

// File: rtl/codificador_4a2_sync.sv
// Registered 4-to-2 priority encoder front end for board request lines.
// The request bus is synchronised, debounced against a snapshot, and each
// accepted press produces one valid strobe, a latched code, a multi-line
// flag and a step of the running event counter. A press must be released
// (synchronised bus back to zero) before another event can be emitted.
module codificador_4a2_sync #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear_cnt,
  input  logic [3:0]       A,
  output logic [1:0]       Y,
  output logic             valid,
  output logic             multi,
  output logic             any,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    EMIT         = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  // Stable-count value that, after one more matching edge, completes debounce.
  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  state_t          state, state_n;
  logic [1:0][3:0] sync_q;
  logic [3:0]      a_s;
  logic [3:0]      snap, snap_n;
  logic [7:0]      deb_cnt, deb_n;
  logic            emit_edge;

  // Highest set bit wins; an all-zero input never reaches this path.
  function automatic logic [1:0] encode(input logic [3:0] v);
    if (v[3])      encode = 2'b11;
    else if (v[2]) encode = 2'b10;
    else if (v[1]) encode = 2'b01;
    else           encode = 2'b00;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic more_than_one(input logic [3:0] v);
    more_than_one = (v & (v - 4'd1)) != 4'd0;
  endfunction

  assign a_s = sync_q[1];
  assign any = |a_s;

  // Two-stage synchroniser for the asynchronous request lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[1] <= sync_q[0];
      sync_q[0] <= A;
    end
  end

  // FSM state, snapshot and stable-edge counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      snap    <= '0;
      deb_cnt <= '0;
    end else begin
      state   <= state_n;
      snap    <= snap_n;
      deb_cnt <= deb_n;
    end
  end

  // Next-state logic: the loading edge counts as stable edge 1.
  always_comb begin
    state_n = state;
    snap_n  = snap;
    deb_n   = deb_cnt;
    unique case (state)
      IDLE: begin
        if (en && a_s != 4'd0) begin
          snap_n  = a_s;
          deb_n   = 8'd1;
          state_n = (DEB_CYCLES == 1) ? EMIT : DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!en || a_s == 4'd0) begin
          state_n = IDLE;
        end else if (a_s != snap) begin
          // A different nonzero pattern restarts the stability window.
          snap_n = a_s;
          deb_n  = 8'd1;
        end else begin
          deb_n = deb_cnt + 8'd1;
          if (deb_cnt == DEB_LAST) state_n = EMIT;
        end
      end
      EMIT: begin
        state_n = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        // Held or changed presses are ignored until the lines go quiet.
        if (a_s == 4'd0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    valid = (state == EMIT);
  end

  assign emit_edge = (state_n == EMIT) && (state != EMIT);

  // Latch code and multi flag on the edge that enters EMIT; hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y     <= 2'b00;
      multi <= 1'b0;
    end else if (emit_edge) begin
      Y     <= encode(snap_n);
      multi <= more_than_one(snap_n);
    end
  end

  // Event counter; a clear on the emitting edge swallows that increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear_cnt) begin
      count <= '0;
    end else if (emit_edge) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: tb/tb_codificador_4a2_sync.sv
// Directed bench for codificador_4a2_sync: an 8-bit-counter instance and a
// 2-bit-counter instance share the same stimulus.
module tb_codificador_4a2_sync;

  logic       clk = 1'b0;
  logic       rst, en, clear_cnt;
  logic [3:0] A;
  logic [1:0] Y, Y2;
  logic       valid, valid2, multi, multi2, any, any2;
  logic [7:0] count8;
  logic [1:0] count2;

  int nchk = 0;
  int nerr = 0;
  int exp8 = 0;
  int exp2 = 0;

  always #5 clk = ~clk;

  codificador_4a2_sync #(.DEB_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .clear_cnt(clear_cnt), .A(A),
    .Y(Y), .valid(valid), .multi(multi), .any(any), .count(count8)
  );

  codificador_4a2_sync #(.DEB_CYCLES(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .clear_cnt(clear_cnt), .A(A),
    .Y(Y2), .valid(valid2), .multi(multi2), .any(any2), .count(count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_Y"}, 32'(Y), 0);
    chk({tag, "_valid"}, 32'(valid), 0);
    chk({tag, "_multi"}, 32'(multi), 0);
    chk({tag, "_any"}, 32'(any), 0);
    chk({tag, "_count8"}, 32'(count8), 0);
    chk({tag, "_count2"}, 32'(count2), 0);
  endtask

  // Apply a press from IDLE with quiet lines; expect the strobe after edge 6.
  task automatic emit(input logic [3:0] a, input logic [1:0] ey, input logic em,
                      input bit clr);
    int pulses;
    A = a;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (valid || valid2) pulses++;
    end
    chk("early_valid", 32'(pulses), 0);
    if (clr) clear_cnt = 1'b1;
    tick();
    clear_cnt = 1'b0;
    if (clr) begin
      exp8 = 0;
      exp2 = 0;
    end else begin
      exp8 = (exp8 + 1) % 256;
      exp2 = (exp2 + 1) % 4;
    end
    chk("valid", 32'(valid), 1);
    chk("valid2", 32'(valid2), 1);
    chk("Y", 32'(Y), 32'(ey));
    chk("Y2", 32'(Y2), 32'(ey));
    chk("multi", 32'(multi), 32'(em));
    chk("count8", 32'(count8), 32'(exp8));
    chk("count2", 32'(count2), 32'(exp2));
    tick();
    chk("valid_one_cycle", 32'(valid), 0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (valid || valid2) pulses++;
    end
    chk("no_repeat", 32'(pulses), 0);
    chk("any_held", 32'(any), 1);
    chk("count_hold", 32'(count8), 32'(exp8));
    chk("Y_hold", 32'(Y), 32'(ey));
  endtask

  task automatic release_lines();
    A = 4'd0;
    repeat (4) tick();
    chk("any_released", 32'(any), 0);
  endtask

  initial begin
    int pulses;
    rst = 1'b1; en = 1'b1; clear_cnt = 1'b0; A = 4'd0;
    tick();
    tick();
    chk_reset_vals("reset");
    rst = 1'b0;

    emit(4'b0100, 2'b10, 1'b0, 1'b0);
    release_lines();
    emit(4'b0001, 2'b00, 1'b0, 1'b0);
    release_lines();
    emit(4'b1010, 2'b11, 1'b1, 1'b0);
    release_lines();

    // Bounce: two short bursts never survive the stability window.
    pulses = 0;
    A = 4'b0010; tick(); tick();
    A = 4'b0000; tick();
    A = 4'b0010; tick(); tick();
    A = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (valid) pulses++;
    end
    chk("bounce_pulses", 32'(pulses), 0);
    chk("bounce_count", 32'(count8), 32'(exp8));
    emit(4'b0010, 2'b01, 1'b0, 1'b0);
    release_lines();

    // Detection disabled while held, then enabled with lines already stable.
    en = 1'b0;
    A = 4'b1000;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid) pulses++;
    end
    chk("en_off_pulses", 32'(pulses), 0);
    en = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (valid) pulses++;
    end
    chk("en_on_early", 32'(pulses), 0);
    tick();
    exp8 = (exp8 + 1) % 256;
    exp2 = (exp2 + 1) % 4;
    chk("en_on_valid", 32'(valid), 1);
    chk("en_on_Y", 32'(Y), 3);
    chk("en_on_count8", 32'(count8), 32'(exp8));
    chk("en_on_count2", 32'(count2), 32'(exp2));
    tick();
    chk("en_on_valid_drop", 32'(valid), 0);
    release_lines();

    // Drop en in the middle of debounce.
    A = 4'b0001;
    repeat (3) tick();
    en = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (valid) pulses++;
    end
    chk("en_drop_pulses", 32'(pulses), 0);
    chk("en_drop_count", 32'(count8), 32'(exp8));
    release_lines();
    en = 1'b1;

    // Sixth event with clear on the emitting edge.
    emit(4'b0100, 2'b10, 1'b0, 1'b1);
    release_lines();

    // Async reset mid-debounce; release with the press still held.
    A = 4'b0100;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1 chk_reset_vals("rst_deb");
    exp8 = 0; exp2 = 0;
    tick();
    tick();
    #2 rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (valid) pulses++;
    end
    chk("post_rst_early", 32'(pulses), 0);
    tick();
    exp8 = 1; exp2 = 1;
    chk("post_rst_valid", 32'(valid), 1);
    chk("post_rst_Y", 32'(Y), 2);
    chk("post_rst_count", 32'(count8), 1);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (valid) pulses++;
    end
    chk("post_rst_single", 32'(pulses), 0);

    // Async reset mid-wait-release: code, count and any drop at once.
    #2 rst = 1'b1;
    #1 chk_reset_vals("rst_wait");
    exp8 = 0; exp2 = 0;
    A = 4'd0;
    tick();
    rst = 1'b0;
    release_lines();

    // Clear outside EMIT.
    emit(4'b0001, 2'b00, 1'b0, 1'b0);
    release_lines();
    clear_cnt = 1'b1;
    tick();
    clear_cnt = 1'b0;
    exp8 = 0; exp2 = 0;
    chk("idle_clear8", 32'(count8), 0);
    chk("idle_clear2", 32'(count2), 0);
    chk("idle_clear_Y", 32'(Y), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
